bin_to_bcd_conv: RTL
====================

BIN_TO_BCD_CONV -- requirements
Module: bin_to_bcd_conv

Interface
REQ-001 Parameter BIN_W, default 16: binary input width; legal range 4..32.
REQ-002 Parameter DIGITS, default 5: number of BCD output digits; legal range 1..10.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 st  input  1  start request, sampled on rising clk.
REQ-006 bin  input  BIN_W  binary operand, captured on an accepted st.
REQ-007 dec  output  4*DIGITS  BCD result; digit 0 (units) in bits [3:0].
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 ok  output  1  high while dec holds a completed result.
REQ-010 ovf  output  1  result exceeded DIGITS digits; valid when ok=1.
REQ-011 neg  output  1  sign of the converted operand; valid when ok=1.

Function
REQ-012 The FSM SHALL have three states, IDLE, SHIFT and DONE; only the transitions IDLE->SHIFT, SHIFT->DONE and DONE->SHIFT are legal.
REQ-013 st=1 in IDLE or DONE SHALL be accepted: capture bin, clear the work registers, enter SHIFT, set busy=1, and clear ok on the same edge.
REQ-014 st SHALL be ignored in SHIFT; the operand captured at the accepted st SHALL be the only one converted.
REQ-015 The SHIFT state SHALL perform one shift-add-3 (double-dabble) step per clock, MSB first, for exactly BIN_W clocks.
REQ-016 Latency: ok=1, busy=0 and dec valid SHALL all hold from BIN_W clock edges after the edge that accepted st.
REQ-017 dec SHALL be updated only on the edge that enters DONE and SHALL otherwise hold its last result, including throughout SHIFT.
REQ-018 Before each shift, any work digit >=5 SHALL have 3 added; each digit stays 4 bits wide, and no digit of a valid result exceeds 9.
REQ-019 A 1 shifted out of the top work digit SHALL set a sticky overflow flag for the current conversion.
REQ-020 On DONE entry with overflow set, dec SHALL saturate to all digits 9 and ovf SHALL be 1; otherwise ovf SHALL be 0.
REQ-021 st held high in DONE SHALL restart a conversion on every completion (back-to-back, one DONE cycle between conversions).
REQ-022 The block SHALL stay in DONE, with its outputs stable, until st=1.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE and dec=0, busy=0, ok=0, ovf=0 and neg=0, independent of clk.
REQ-024 A reset asserted mid-conversion SHALL abort the conversion, and no ok pulse SHALL follow.
REQ-025 The first accepted st after rst_n rises SHALL behave as from IDLE.

Configuration
REQ-026 With macro BIN_TO_BCD_SIGNED_EN defined, bin SHALL be treated as two's complement.
REQ-027 Under BIN_TO_BCD_SIGNED_EN, neg SHALL equal bin[BIN_W-1], and the magnitude (-bin when negative) SHALL be converted as an unsigned BIN_W-bit value.
REQ-028 Under BIN_TO_BCD_SIGNED_EN, -2^(BIN_W-1) SHALL convert to magnitude 2^(BIN_W-1) without error.
REQ-029 Without BIN_TO_BCD_SIGNED_EN, bin SHALL be unsigned, and neg SHALL remain a port tied to constant 0.

Verification
REQ-030 Defaults, bin=16'd12345, st for 1 cycle -> ok rises after exactly 16 edges with dec=20'h12345, ovf=0, busy=0.
REQ-031 Defaults, bin=16'hFFFF (unsigned build) -> dec=20'h65535, ovf=0; separately, DIGITS=4 with bin=16'd10000 -> dec=16'h9999, ovf=1.
REQ-032 Start with bin=16'd9999, then pulse st with bin=16'd1 at SHIFT cycle 5 -> dec=20'h09999, and ok rises at the original 16-edge point.
REQ-033 rst_n low at SHIFT cycle 8 of a conversion -> all outputs 0 immediately, state IDLE, and ok stays 0 after rst_n releases with st=0.
REQ-034 BIN_TO_BCD_SIGNED_EN, bin=16'h8000 -> neg=1, dec=20'h32768; bin=16'hFFFF -> neg=1, dec=20'h00001; bin=16'd0 -> neg=0, dec=0.
REQ-035 st held high with bin=16'd42 -> dec=20'h00042 and ok=1 for one cycle every 17 cycles, with busy=1 in between.

Source files
------------

// File: rtl/bin_to_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock, MSB first).
// Define BIN_TO_BCD_SIGNED_EN to treat bin as two's complement and report its sign on neg.
module bin_to_bcd_conv #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   dec,
  output logic                  busy,
  output logic                  ok,
  output logic                  ovf,
  output logic                  neg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [BIN_W-1:0]  opnd;
  logic [BCD_W-1:0]  work;
  logic              ovf_st;
  logic              sign_cap;
  logic              sign_in;
  logic [BIN_W-1:0]  mag_in;
  logic              accept;
  logic              last;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  shifted;
  logic              carry;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] w);
    logic [BCD_W-1:0] r;
    r = w;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] w, input logic o);
    return o ? {DIGITS{4'h9}} : w;
  endfunction

`ifdef BIN_TO_BCD_SIGNED_EN
  logic signed [BIN_W-1:0] bin_s;
  logic signed [BIN_W-1:0] bin_neg;
  assign bin_s   = bin;
  assign bin_neg = -bin_s;
  assign sign_in = bin[BIN_W-1];
  // -2^(BIN_W-1) negates to itself, which read unsigned is the right magnitude
  assign mag_in  = sign_in ? bin_neg : bin;
`else
  assign sign_in = 1'b0;
  assign mag_in  = bin;
`endif

  assign accept  = st && (state != SHIFT);
  assign last    = (cnt == CNT_W'(BIN_W - 1));
  assign adj     = add3(work);
  assign shifted = {adj[BCD_W-2:0], opnd[BIN_W-1]};
  assign carry   = adj[BCD_W-1];

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ok        = 1'b0;
    case (state)
      IDLE:  if (st) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ok = 1'b1;
        if (st) state_nxt = SHIFT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dec   <= '0;
      ovf   <= 1'b0;
      neg   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) cnt <= '0;
      else if (state == SHIFT) cnt <= cnt + 1'b1;
      // Result registers change only on the edge that enters DONE
      if (state == SHIFT && last) begin
        dec <= saturate(shifted, ovf_st | carry);
        ovf <= ovf_st | carry;
        neg <= sign_cap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      opnd     <= mag_in;
      work     <= '0;
      ovf_st   <= 1'b0;
      sign_cap <= sign_in;
    end else if (state == SHIFT) begin
      opnd     <= opnd << 1;
      work     <= shifted;
      ovf_st   <= ovf_st | carry;
    end
  end

endmodule
